// File: rtl/sample_stream_pkg.sv
// Shared types and helpers for the sample stream deframer.
// FSM state encoding, byte-count helper and sticky-flag bit positions.
package sample_stream_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_COLLECT
  } state_e;

  localparam int unsigned FLAG_OVERFLOW = 0;
  localparam int unsigned FLAG_FRAME    = 1;
  localparam int unsigned FLAG_TIMEOUT  = 2;
  localparam int unsigned NUM_FLAGS     = 3;

  function automatic int unsigned bytes_per_sample(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/byte_shift_assembler.sv
// Byte-to-sample datapath: accumulator, byte counter and completion detect.
// data_next carries the sample including the byte taken this cycle.
module byte_shift_assembler
  import sample_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  take,
  input  logic                  restart,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] data_next,
  output logic                  complete
);

  localparam int unsigned BYTES = bytes_per_sample(DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  logic [DATA_WIDTH-1:0] data_q, data_d, base_data;
  logic [CNT_W-1:0]      cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_cnt  = restart ? '0 : cnt_q;
    base_data = restart ? '0 : data_q;
    data_next = base_data;
    data_d    = data_q;
    cnt_d     = cnt_q;
    complete  = 1'b0;
    if (take) begin
      if (MSB_FIRST != 0) begin
        data_next = (base_data << 8) | DATA_WIDTH'(byte_in);
      end else begin
        for (int i = 0; i < BYTES; i++) begin
          if (base_cnt == CNT_W'(i)) data_next[8*i +: 8] = byte_in;
        end
      end
      if (base_cnt == CNT_W'(BYTES - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        data_d   = '0;
      end else begin
        cnt_d  = base_cnt + CNT_W'(1);
        data_d = data_next;
      end
    end else if (abort) begin
      cnt_d  = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_stream_deframer.sv
// Byte-stream deframer: assembles unit-tagged samples into a valid/ready slot.
// Optional DEFRAMER_COUNT_EN adds per-unit accepted-sample counters.
module sample_stream_deframer
  import sample_stream_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SEL_W          = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic [SEL_W-1:0]      unit_sel,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic [SEL_W-1:0]      sample_unit,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_err,
  output logic                  timeout_err,
  input  logic                  clear_err
`ifdef DEFRAMER_COUNT_EN
  ,
  input  logic [SEL_W-1:0]      stat_sel,
  output logic [15:0]           stat_count
`endif
);

  localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      tag_q, tag_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  slot_valid_q, slot_valid_d;
  logic [DATA_WIDTH-1:0] slot_data_q, slot_data_d;
  logic [SEL_W-1:0]      slot_unit_q, slot_unit_d;
  logic [NUM_FLAGS-1:0]  flags_q, flags_d, flag_set;

  logic                  mismatch, restart, timeout_hit, accept, complete;
  logic [DATA_WIDTH-1:0] data_next;

  byte_shift_assembler #(
    .DATA_WIDTH(DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .take     (byte_valid),
    .restart  (restart),
    .abort    (timeout_hit),
    .byte_in  (byte_in),
    .data_next(data_next),
    .complete (complete)
  );

  always_comb begin
    mismatch    = (state_q == ST_COLLECT) && byte_valid && (unit_sel != tag_q);
    restart     = byte_valid && ((state_q == ST_IDLE) || mismatch);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ST_COLLECT) && !byte_valid &&
                  (idle_q == IDLE_W'(TO_LAST));
    accept      = slot_valid_q && sample_ready;

    state_d  = state_q;
    tag_d    = restart ? unit_sel : tag_q;
    idle_d   = '0;
    flag_set = '0;

    if (byte_valid) begin
      state_d = complete ? ST_IDLE : ST_COLLECT;
    end else if (timeout_hit) begin
      state_d                = ST_IDLE;
      flag_set[FLAG_TIMEOUT] = 1'b1;
    end else if (state_q == ST_COLLECT) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (mismatch) flag_set[FLAG_FRAME] = 1'b1;

    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    slot_unit_d  = slot_unit_q;
    if (complete) begin
      if (!slot_valid_q || accept) begin
        slot_valid_d = 1'b1;
        slot_data_d  = data_next;
        slot_unit_d  = tag_d;
      end else begin
        flag_set[FLAG_OVERFLOW] = 1'b1;
      end
    end else if (accept) begin
      slot_valid_d = 1'b0;
    end

    // New events win over a same-cycle clear.
    flags_d = (clear_err ? '0 : flags_q) | flag_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      idle_q       <= '0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_unit_q  <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idle_q       <= idle_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_unit_q  <= slot_unit_d;
      flags_q      <= flags_d;
    end
  end

  assign sample_out   = slot_data_q;
  assign sample_unit  = slot_unit_q;
  assign sample_valid = slot_valid_q;
  assign busy         = (state_q == ST_COLLECT);
  assign overflow     = flags_q[FLAG_OVERFLOW];
  assign frame_err    = flags_q[FLAG_FRAME];
  assign timeout_err  = flags_q[FLAG_TIMEOUT];

`ifdef DEFRAMER_COUNT_EN
  logic [15:0] count_q [NUM_UNITS];
  logic [15:0] stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_UNITS; i++) count_q[i] <= '0;
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (accept && (slot_unit_q == SEL_W'(i))) begin
          count_q[i] <= (clear_err ? 16'd0 : count_q[i]) + 16'd1;
        end else if (clear_err) begin
          count_q[i] <= '0;
        end
      end
      stat_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (stat_sel == SEL_W'(i)) stat_q <= count_q[i];
      end
    end
  end

  assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_sample_stream_deframer.sv
// Scoreboard bench: stimulus pushes expected samples, monitors pop on handshake.
// Optional DEFRAMER_COUNT_EN also exercises the per-unit counters.
module tb_sample_stream_deframer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 16-bit, MSB first, short timeout.
  logic [7:0]  a_byte = '0;
  logic        a_bv = 1'b0;
  logic [1:0]  a_sel = '0;
  logic [15:0] a_out;
  logic [1:0]  a_unit;
  logic        a_valid, a_busy, a_ovf, a_frm, a_to;
  logic        a_ready = 1'b1;
  logic        a_clr = 1'b0;
`ifdef DEFRAMER_COUNT_EN
  logic [1:0]  a_stat_sel = '0;
  logic [15:0] a_stat;
`endif

  sample_stream_deframer #(
    .NUM_UNITS     (4),
    .DATA_WIDTH    (16),
    .MSB_FIRST     (1),
    .TIMEOUT_CYCLES(4)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (a_byte),
    .byte_valid  (a_bv),
    .unit_sel    (a_sel),
    .sample_out  (a_out),
    .sample_unit (a_unit),
    .sample_valid(a_valid),
    .sample_ready(a_ready),
    .busy        (a_busy),
    .overflow    (a_ovf),
    .frame_err   (a_frm),
    .timeout_err (a_to),
    .clear_err   (a_clr)
`ifdef DEFRAMER_COUNT_EN
    ,
    .stat_sel    (a_stat_sel),
    .stat_count  (a_stat)
`endif
  );

  // Instance B: 24-bit, LSB first, timeout disabled.
  logic [7:0]  b_byte = '0;
  logic        b_bv = 1'b0;
  logic [1:0]  b_sel = '0;
  logic [23:0] b_out;
  logic [1:0]  b_unit;
  logic        b_valid, b_busy, b_ovf, b_frm, b_to;
`ifdef DEFRAMER_COUNT_EN
  logic [15:0] b_stat;
`endif

  sample_stream_deframer #(
    .NUM_UNITS     (4),
    .DATA_WIDTH    (24),
    .MSB_FIRST     (0),
    .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (b_byte),
    .byte_valid  (b_bv),
    .unit_sel    (b_sel),
    .sample_out  (b_out),
    .sample_unit (b_unit),
    .sample_valid(b_valid),
    .sample_ready(1'b1),
    .busy        (b_busy),
    .overflow    (b_ovf),
    .frame_err   (b_frm),
    .timeout_err (b_to),
    .clear_err   (1'b0)
`ifdef DEFRAMER_COUNT_EN
    ,
    .stat_sel    (2'd0),
    .stat_count  (b_stat)
`endif
  );

  logic [17:0] exp_a [$];  // {unit, data}
  logic [25:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitors: compare every accepted sample against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: got unit %0d data 0x%0h expected none", a_unit, a_out);
      end else begin
        logic [17:0] e;
        e = exp_a.pop_front();
        if ({a_unit, a_out} !== e) begin
          errors++;
          $display("FAIL a_sample: got unit %0d data 0x%0h expected unit %0d data 0x%0h",
                   a_unit, a_out, e[17:16], e[15:0]);
        end
      end
    end
    if (!rst && b_valid) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got unit %0d data 0x%0h expected none", b_unit, b_out);
      end else begin
        logic [25:0] e;
        e = exp_b.pop_front();
        if ({b_unit, b_out} !== e) begin
          errors++;
          $display("FAIL b_sample: got unit %0d data 0x%0h expected unit %0d data 0x%0h",
                   b_unit, b_out, e[25:24], e[23:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b, input logic [1:0] u);
    a_byte = b;
    a_sel  = u;
    a_bv   = 1'b1;
    step(1);
    a_bv   = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_byte = b;
    b_bv   = 1'b1;
    step(1);
    b_bv   = 1'b0;
  endtask

  task automatic pulse_clear();
    a_clr = 1'b1;
    step(1);
    a_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    check("reset_out", {14'd0, a_unit, a_out}, 32'd0);
    check("reset_flags", {a_valid, a_busy, a_ovf, a_frm, a_to}, 32'd0);

    // Basic MSB-first sample.
    exp_a.push_back({2'd2, 16'h1234});
    send_a(8'h12, 2'd2);
    check("busy_first", a_busy, 1);
    send_a(8'h34, 2'd2);
    check("busy_done", a_busy, 0);
    check("valid_n1", a_valid, 1);
    step(1);
    check("valid_drop", a_valid, 0);

    // LSB-first, 24-bit.
    exp_b.push_back({2'd0, 24'hCCBBAA});
    send_b(8'hAA);
    send_b(8'hBB);
    send_b(8'hCC);
    step(2);

    // Overflow with a stalled slot.
    a_ready = 1'b0;
    exp_a.push_back({2'd0, 16'h0001});
    send_a(8'h00, 2'd0);
    send_a(8'h01, 2'd0);
    check("ovf_before", a_ovf, 0);
    send_a(8'h00, 2'd0);
    send_a(8'h02, 2'd0);
    check("ovf_set", a_ovf, 1);
    check("ovf_hold", a_out, 32'h0001);
    a_ready = 1'b1;
    step(1);
    check("ovf_drain", a_valid, 0);
    pulse_clear();
    check("ovf_clear", a_ovf, 0);

    // Unit change mid-sample.
    exp_a.push_back({2'd1, 16'h6677});
    send_a(8'h55, 2'd0);
    send_a(8'h66, 2'd1);
    send_a(8'h77, 2'd1);
    check("frame_set", a_frm, 1);
    step(1);

    // Timeout after four idle cycles.
    send_a(8'h11, 2'd3);
    step(3);
    check("to_busy_pre", a_busy, 1);
    check("to_flag_pre", a_to, 0);
    step(1);
    check("to_busy", a_busy, 0);
    check("to_flag", a_to, 1);
    exp_a.push_back({2'd2, 16'h9ABC});
    send_a(8'h9A, 2'd2);
    send_a(8'hBC, 2'd2);
    step(1);
    pulse_clear();
    check("clear_flags", {a_ovf, a_frm, a_to}, 0);

    // Byte in the would-be timeout cycle wins.
    exp_a.push_back({2'd1, 16'h0102});
    send_a(8'h01, 2'd1);
    step(3);
    send_a(8'h02, 2'd1);
    check("to_byte_wins", a_to, 0);
    step(1);

`ifdef DEFRAMER_COUNT_EN
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back({2'd1, 16'h2000 + 16'(i)});
      send_a(8'h20, 2'd1);
      send_a(8'(i), 2'd1);
    end
    exp_a.push_back({2'd3, 16'h4142});
    send_a(8'h41, 2'd3);
    send_a(8'h42, 2'd3);
    step(2);
    a_stat_sel = 2'd1;
    step(2);
    check("stat_unit1", a_stat, 3);
    a_stat_sel = 2'd3;
    step(2);
    check("stat_unit3", a_stat, 1);
`endif

    // Reset mid-sample discards the partial byte.
    send_a(8'hAA, 2'd1);
    rst = 1'b1;
    step(1);
    check("rst_out", {14'd0, a_unit, a_out}, 32'd0);
    check("rst_flags", {a_valid, a_busy, a_ovf, a_frm, a_to}, 32'd0);
    rst = 1'b0;
    step(1);
    exp_a.push_back({2'd0, 16'h0304});
    send_a(8'h03, 2'd0);
    send_a(8'h04, 2'd0);
    step(3);

    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_stream_deframer.md
Name: sample_stream_deframer

Overview:
Parametrised byte-stream front end for the spike-detection array. It assembles DATA_WIDTH-bit samples from a strobed 8-bit byte bus and tags each with the unit index sampled on its first byte. It presents samples to the per-unit detectors through a registered valid/ready output slot. It is the generalised successor of the fixed 2-byte, 2/4-unit intake: any byte count, any unit count, selectable byte order, timeout recovery, and error flags.

Parameters:
NUM_UNITS, 4, number of detector units addressed (>=1)
DATA_WIDTH, 16, sample width; multiple of 8, >=8
SEL_W, (NUM_UNITS>1 ? $clog2(NUM_UNITS) : 1), unit-select width (derived)
MSB_FIRST, 1, 1 = first byte is bits [DATA_WIDTH-1:DATA_WIDTH-8]; 0 = first byte is [7:0]
TIMEOUT_CYCLES, 64, idle cycles tolerated inside a partial sample; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
byte_in  in  8  data byte
byte_valid  in  1  byte_in is valid this cycle; one byte per high cycle
unit_sel  in  SEL_W  target unit; captured with the first byte of each sample
sample_out  out  DATA_WIDTH  assembled sample
sample_unit  out  SEL_W  unit tag of sample_out
sample_valid  out  1  output slot occupied
sample_ready  in  1  downstream accepts when sample_valid && sample_ready
busy  out  1  partial sample in progress
overflow  out  1  sticky: completed sample dropped because the slot was full
frame_err  out  1  sticky: unit_sel changed mid-sample
timeout_err  out  1  sticky: partial sample abandoned after timeout
clear_err  in  1  synchronous clear of all sticky flags

Behaviour:
- Reset: all outputs 0, byte counter 0, state IDLE, slot empty. Reset mid-sample discards the partial sample.
- BYTES = DATA_WIDTH/8. Byte counter width is $clog2(BYTES+1).
- FSM states:
  - IDLE: a byte on byte_valid captures unit_sel, loads the byte, goes to COLLECT. If BYTES==1 it completes immediately and stays IDLE.
  - COLLECT: each byte shifts in (MSB_FIRST: shift left and insert at [7:0]; else insert at byte position cnt). On byte BYTES it completes and returns to IDLE.
- busy = (state==COLLECT).
- Latency: completion on cycle N gives sample_valid=1 at cycle N+1, with sample_out/sample_unit stable until accepted.
- Slot rules:
  - The slot is freed by handshake.
  - If completion occurs while the slot is full and not being accepted that cycle, the new sample is dropped, the slot keeps the old sample, and overflow is set.
  - Accept and completion in the same cycle: the slot is reloaded and sample_valid stays 1, with no overflow.
- Unit-select change: in COLLECT, a byte whose unit_sel differs from the captured tag sets frame_err. The partial sample is discarded and that byte starts a new sample for the new unit.
- Timeout: an idle counter clears on every byte and counts in COLLECT only. When it reaches TIMEOUT_CYCLES with no byte, the partial sample is discarded, timeout_err is set, and the state returns to IDLE. A byte arriving in the timeout cycle wins (no timeout).
- clear_err clears the sticky flags. A same-cycle set takes precedence over clear_err.
- Collection never stalls; backpressure only affects the slot.

Optional Feature:
DEFRAMER_COUNT_EN:
- Defined: adds ports stat_sel (in, SEL_W) and stat_count (out, 16). It keeps one 16-bit wrapping counter per unit, incremented on each sample accepted by handshake. stat_count is the registered counter[stat_sel] (1-cycle latency). clear_err also zeroes all counters.
- Undefined: no counters and no extra ports.

Decomposition:
- Package sample_stream_pkg:
  - FSM state enum (ST_IDLE, ST_COLLECT)
  - function bytes_per_sample(width)
  - sticky-flag index constants
- Sub-module: byte_shift_assembler (shift/insert datapath plus byte counter). The FSM, slot and flags stay in the top.

Test Plan:
- DATA_WIDTH=16, MSB_FIRST=1, unit 2, bytes 0x12,0x34, ready=1 -> one sample_valid cycle, sample_out=0x1234, sample_unit=2, busy 1 for one cycle.
- MSB_FIRST=0, DATA_WIDTH=24, bytes 0xAA,0xBB,0xCC -> sample_out=0xCCBBAA.
- ready=0, two complete samples 0x0001 then 0x0002 -> slot holds 0x0001, overflow=1; then ready=1 -> 0x0001 accepted, sample_valid drops.
- byte 0x55 unit 0, then byte 0x66 unit 1, then 0x77 unit 1 -> frame_err=1, output 0x6677 tagged unit 1.
- TIMEOUT_CYCLES=4, one byte then 4 idle cycles -> timeout_err=1, busy=0; next two bytes 0x9A,0xBC -> 0x9ABC. clear_err -> flags 0.
- DEFRAMER_COUNT_EN: 3 samples to unit 1, 1 to unit 3 -> stat_count reads 3 (stat_sel=1) and 1 (stat_sel=3); reset mid-sample (rst pulse after 1 byte) -> all outputs 0, no spurious sample.
